// File: rtl/elastic_pipe_pkg.sv
// elastic_pipe shared constants and helpers.
// Occupancy width helper and drop counter limits.
package elastic_pipe_pkg;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  function automatic int occ_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: one valid/data register pair.
// Moves when ready; a flush clears valid and reports any loss.
module elastic_pipe_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             rdy,
  output logic             drop
);

  assign rdy  = !valid | dn_ready;
  assign drop = flush & ((valid & !rdy) | (rdy & up_valid));

  // load on ready, hold otherwise; flush clears valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (rdy)
        valid <= up_valid;
      if (rdy && up_valid)
        data <= up_data;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe: valid/ready pipeline with flush and occupancy.
// ELASTIC_PIPE_SKID_BUF_EN adds a skid entry ahead of stage 0.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
`ifdef ELASTIC_PIPE_SKID_BUF_EN
  parameter int OCC_W  = occ_width(STAGES + 1)
`else
  parameter int OCC_W  = occ_width(STAGES)
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  input  logic [STAGES-1:0]     flush_mask,
  output logic [OCC_W-1:0]      occupancy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [STAGES-1:0]            v;
  logic [STAGES-1:0]            rdy;
  logic [STAGES-1:0]            drop;
  logic [STAGES-1:0]            up_v;
  logic [STAGES-1:0]            dn_r;
  logic [STAGES-1:0][WIDTH-1:0] d;
  logic [STAGES-1:0][WIDTH-1:0] up_d;
  logic                         s0_valid;
  logic [WIDTH-1:0]             s0_data;
  logic                         skid_drop;
  logic [OCC_W-1:0]             skid_occ;

`ifdef ELASTIC_PIPE_SKID_BUF_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign in_ready  = !skid_valid;
  assign s0_valid  = skid_valid | in_valid;
  assign s0_data   = skid_valid ? skid_data : in_data;
  assign skid_drop = flush_mask[0] & !rdy[0]
                   & (skid_valid | in_valid);
  assign skid_occ  = OCC_W'(skid_valid);

  // skid catches a word stage 0 cannot take, drains first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (flush_mask[0])
        skid_valid <= 1'b0;
      else if (skid_valid)
        skid_valid <= !rdy[0];
      else
        skid_valid <= in_valid & !rdy[0];
      if (!skid_valid && in_valid && !rdy[0])
        skid_data <= in_data;
    end
  end
`else
  assign in_ready  = rdy[0];
  assign s0_valid  = in_valid;
  assign s0_data   = in_data;
  assign skid_drop = 1'b0;
  assign skid_occ  = '0;
`endif

  // wire each stage to its upstream source and downstream ready
  always_comb begin
    up_v    = '0;
    up_d    = '0;
    dn_r    = '0;
    up_v[0] = s0_valid;
    up_d[0] = s0_data;
    for (int i = 1; i < STAGES; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
    for (int i = 0; i < STAGES - 1; i++)
      dn_r[i] = rdy[i+1];
    dn_r[STAGES-1] = out_ready;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    elastic_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .up_valid(up_v[i]),
      .up_data (up_d[i]),
      .dn_ready(dn_r[i]),
      .flush   (flush_mask[i]),
      .valid   (v[i]),
      .data    (d[i]),
      .rdy     (rdy[i]),
      .drop    (drop[i])
    );
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  // popcount of valid entries, skid included when present
  always_comb begin
    occupancy = skid_occ;
    for (int i = 0; i < STAGES; i++)
      occupancy = occupancy + OCC_W'(v[i]);
  end

  logic [DROP_CNT_W:0] drop_sum;
  logic [DROP_CNT_W:0] drop_nxt;

  // total losses this edge, added with saturation
  always_comb begin
    drop_sum = (DROP_CNT_W+1)'(skid_drop);
    for (int i = 0; i < STAGES; i++)
      drop_sum = drop_sum + (DROP_CNT_W+1)'(drop[i]);
    drop_nxt = {1'b0, drop_cnt} + drop_sum;
  end

  // saturating squash counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (drop_nxt > {1'b0, DROP_CNT_MAX})
      drop_cnt <= DROP_CNT_MAX;
    else
      drop_cnt <= drop_nxt[DROP_CNT_W-1:0];
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: scoreboard bench for elastic_pipe.
// Runs the skid scenario when ELASTIC_PIPE_SKID_BUF_EN is set.
module tb_elastic_pipe;

  localparam int W = 32;
  localparam int S = 4;
`ifdef ELASTIC_PIPE_SKID_BUF_EN
  localparam logic FULL_RDY = 1'b1;
`else
  localparam logic FULL_RDY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [S-1:0] flush_mask = '0;
  logic [2:0]   occupancy;
  logic [15:0]  drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  elastic_pipe #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush_mask(flush_mask),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
  );

  task automatic tick(output logic got,
                      output logic [W-1:0] dat);
    @(negedge clk);
    got = out_valid & out_ready;
    dat = out_data;
    if (in_valid && in_ready)
      sb.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 ||
        drop_cnt !== 16'd0 || in_ready !== 1'b1 ||
        out_data !== '0) begin
      errors++;
      $display("FAIL reset ov=%b occ=%0d drop=%0d ir=%b od=%h",
               out_valid, occupancy, drop_cnt, in_ready, out_data);
    end
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming;
    logic got;
    logic [W-1:0] dat, exp;
    int first_out, n;
    first_out = -1;
    n = 0;
    sb.delete();
    out_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      in_valid = (t < 20);
      in_data  = W'(t + 1);
      tick(got, dat);
      if (got) begin
        if (first_out < 0) first_out = t;
        n++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stream_extra got=%h", dat);
        end else begin
          exp = sb.pop_front();
          if (dat !== exp) begin
            errors++;
            $display("FAIL stream_data got=%h exp=%h", dat, exp);
          end
        end
      end
      if (t == 8) begin
        checks++;
        if (occupancy !== 3'd4) begin
          errors++;
          $display("FAIL stream_occ got=%0d exp=4", occupancy);
        end
      end
      if (t >= 20 && sb.size() == 0) break;
    end
    in_valid = 1'b0;
    checks++;
    if (first_out != S) begin
      errors++;
      $display("FAIL stream_latency got=%0d exp=%0d", first_out, S);
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL stream_count got=%0d exp=20", n);
    end
  endtask

  task automatic test_backpressure;
    logic got;
    logic [W-1:0] dat, exp;
    int n;
    n = 0;
    sb.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'hA0 + i);
      tick(got, dat);
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd4 || in_ready !== FULL_RDY) begin
      errors++;
      $display("FAIL bp_full occ=%0d ir=%b exp occ=4 ir=%b",
               occupancy, in_ready, FULL_RDY);
    end
    tick(got, dat);
    checks++;
    if (occupancy !== 3'd4 || out_valid !== 1'b1 ||
        out_data !== 32'hA0) begin
      errors++;
      $display("FAIL bp_hold occ=%0d ov=%b od=%h exp 4 1 a0",
               occupancy, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      tick(got, dat);
      if (got) begin
        n++;
        exp = sb.pop_front();
        checks++;
        if (dat !== exp) begin
          errors++;
          $display("FAIL bp_data got=%h exp=%h", dat, exp);
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=4", n);
    end
  endtask

  task automatic test_bubble;
    logic got;
    logic [W-1:0] dat, exp;
    int n;
    n = 0;
    sb.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB0;
    tick(got, dat);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick(got, dat);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hB0 ||
        occupancy !== 3'd1) begin
      errors++;
      $display("FAIL bubble_tail ov=%b od=%h occ=%0d exp 1 b0 1",
               out_valid, out_data, occupancy);
    end
    for (int i = 1; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'hB0 + i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bubble_ready i=%0d got=%b exp=1", i, in_ready);
      end
      tick(got, dat);
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd4) begin
      errors++;
      $display("FAIL bubble_occ got=%0d exp=4", occupancy);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      tick(got, dat);
      if (got) begin
        n++;
        exp = sb.pop_front();
        checks++;
        if (dat !== exp) begin
          errors++;
          $display("FAIL bubble_data got=%h exp=%h", dat, exp);
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bubble_count got=%0d exp=4", n);
    end
  endtask

  task automatic test_flush;
    logic got;
    logic [W-1:0] dat, exp;
    int n;
    n = 0;
    sb.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'hD0 + i);
      tick(got, dat);
    end
    in_valid   = 1'b0;
    flush_mask = 4'b0110;
    tick(got, dat);
    flush_mask = '0;
    sb.delete(2);
    sb.delete(1);
    checks++;
    if (occupancy !== 3'd2 || drop_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flush_mid occ=%0d drop=%0d exp 2 2",
               occupancy, drop_cnt);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      tick(got, dat);
      if (got) begin
        n++;
        exp = sb.pop_front();
        checks++;
        if (dat !== exp) begin
          errors++;
          $display("FAIL flush_data got=%h exp=%h", dat, exp);
        end
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL flush_count got=%0d exp=2", n);
    end
  endtask

  task automatic test_flush_out;
    logic got;
    logic [W-1:0] dat, exp;
    int n;
    n = 0;
    sb.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'hE0 + i);
      tick(got, dat);
    end
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    flush_mask = 4'b1000;
    tick(got, dat);
    flush_mask = '0;
    out_ready  = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (got !== 1'b1 || dat !== exp) begin
      errors++;
      $display("FAIL flushout_xfer got=%b/%h exp=1/%h", got, dat, exp);
    end
    sb.delete(0);
    checks++;
    if (drop_cnt !== 16'd3 || occupancy !== 3'd2) begin
      errors++;
      $display("FAIL flushout_cnt drop=%0d occ=%0d exp 3 2",
               drop_cnt, occupancy);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      tick(got, dat);
      if (got) begin
        n++;
        exp = sb.pop_front();
        checks++;
        if (dat !== exp) begin
          errors++;
          $display("FAIL flushout_data got=%h exp=%h", dat, exp);
        end
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL flushout_count got=%0d exp=2", n);
    end
  endtask

  task automatic test_reset_mid;
    logic got;
    logic [W-1:0] dat;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'hF0 + i);
      tick(got, dat);
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_pre occ=%0d exp=3", occupancy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 ||
        drop_cnt !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid ov=%b occ=%0d drop=%0d ir=%b exp 0 0 0 1",
               out_valid, occupancy, drop_cnt, in_ready);
    end
    sb.delete();
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick(got, dat);
    checks++;
    if (got !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_after ov=%b occ=%0d exp 0 0",
               got, occupancy);
    end
  endtask

`ifdef ELASTIC_PIPE_SKID_BUF_EN
  task automatic test_skid;
    logic got;
    logic [W-1:0] dat, exp;
    int n;
    n = 0;
    sb.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'h90 + i);
      tick(got, dat);
    end
    in_data = 32'hC0;
    tick(got, dat);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 3'd5) begin
      errors++;
      $display("FAIL skid_full ir=%b occ=%0d exp 0 5",
               in_ready, occupancy);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      tick(got, dat);
      if (got) begin
        n++;
        exp = sb.pop_front();
        checks++;
        if (dat !== exp) begin
          errors++;
          $display("FAIL skid_data got=%h exp=%h", dat, exp);
        end
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL skid_count got=%0d exp=5", n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_flush_out();
    test_reset_mid();
`ifdef ELASTIC_PIPE_SKID_BUF_EN
    test_skid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
